// File: rtl/line_window_3x3_pkg.sv
// Shared types and helpers for the 3x3 window assembler.
package win_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WIN_TAPS = 9;

  // Bit offset of window element (r,c) inside the packed window bus.
  function automatic int win_idx(input int r, input int c, input int width);
    return width * (3 * r + c);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line pixel delay: data_out is the pixel written DEPTH enabled cycles
// earlier. Storage is intentionally not reset; the consumer masks stale data.
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Shift the delay line by one position on each enabled cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (en) begin
      mem_d[0] = data_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // Delay-line storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign data_out = mem_q[DEPTH-1];

endmodule

// File: rtl/line_window_3x3_counter.sv
// Free-running up counter with synchronous clear; clear wins over enable.
module up_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: clear to zero, else step when enabled, else hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/line_window_3x3.sv
// Assembles a registered 3x3 neighbourhood from the live pixel and two
// line-delayed taps, tracks raster position, and flags interior windows and
// end of frame. Row 0 of the window is the oldest line, column 0 the oldest
// pixel.
module line_window_3x3
  import win_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [WIDTH-1:0]            pix_in,
  input  logic [WIDTH-1:0]            tap1,
  input  logic [WIDTH-1:0]            tap2,
  output logic                        lb_en,
  output logic [WIN_TAPS*WIDTH-1:0]   win_out,
  output logic                        win_valid,
  output logic                        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if (IMG_W < 3 || IMG_H < 3) begin : g_bad_size
    $error("line_window_3x3: IMG_W and IMG_H must both be at least 3");
  end

  logic [CW-1:0]    col;
  logic             col_last;
  logic [RW-1:0]    row_d, row_q;
  state_t           state_d, state_q;
  logic             win_valid_d, win_valid_q;
  logic             frame_done_d, frame_done_q;
  logic [WIDTH-1:0] win_d [3][3];
  logic [WIDTH-1:0] win_q [3][3];

  // Line buffers advance exactly when a pixel is accepted.
  assign lb_en    = en;
  assign col_last = (col == COL_LAST);

  up_counter #(
    .W(CW)
  ) u_col_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (col_last && en),
    .en   (en),
    .count(col)
  );

  // Row tracking, FILL/RUN sequencing and output strobes.
  always_comb begin
    row_d        = row_q;
    state_d      = state_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (en) begin
      // Columns 0 and 1 would splice the previous line's tail into the window.
      win_valid_d = (state_q == RUN) && (col >= CW'(2));
      if (col_last) begin
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        case (state_q)
          FILL: begin
            if (row_q == RW'(1)) begin
              state_d = RUN;
            end
          end
          RUN: begin
            if (row_q == ROW_LAST) begin
              state_d      = FILL;
              frame_done_d = 1'b1;
            end
          end
          default: state_d = FILL;
        endcase
      end
    end
  end

  // Window shift: older columns move left, the new column enters at c=2.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end
    if (en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = tap2;
      win_d[1][2] = tap1;
      win_d[2][2] = pix_in;
    end
  end

  // Control and window registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q        <= '0;
      state_q      <= FILL;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      row_q        <= row_d;
      state_q      <= state_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  // Flatten the window array onto the output bus.
  always_comb begin
    win_out = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_out[win_idx(r, c, WIDTH) +: WIDTH] = win_q[r][c];
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 on a 4x4 frame with real line buffers.
module tb_line_window_3x3;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] pix_in;
  logic [WIDTH-1:0] tap1;
  logic [WIDTH-1:0] tap2;
  logic             lb_en;
  logic [71:0]      win_out;
  logic             win_valid;
  logic             frame_done;

  int checks = 0;
  int errors = 0;
  int nwin   = 0;
  int nfd    = 0;
  logic [71:0] sb [$];
  logic [71:0] last_win = '0;

  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .en(lb_en), .data_in(pix_in), .data_out(tap1)
  );
  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb2 (
    .clk(clk), .en(lb_en), .data_in(tap1), .data_out(tap2)
  );

  line_window_3x3 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pix_in    (pix_in),
    .tap1      (tap1),
    .tap2      (tap2),
    .lb_en     (lb_en),
    .win_out   (win_out),
    .win_valid (win_valid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  // Window centred on (r-1, c-1), built from the frame's pixel formula.
  function automatic logic [71:0] win_exp(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        w[8*(3*wr+wc) +: 8] = pix(r - 2 + wr, c - 2 + wc);
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check lb_en, then check registered outputs.
  task automatic step(input logic e, input int r, input int c);
    logic exp_v;
    logic exp_fd;
    logic [71:0] got;
    en     = e;
    pix_in = e ? pix(r, c) : 8'h00;
    exp_v  = e && (r >= 2) && (c >= 2);
    exp_fd = e && (r == IMG_H - 1) && (c == IMG_W - 1);
    if (exp_v) sb.push_back(win_exp(r, c));
    #1;
    chk("lb_en", 72'(lb_en), 72'(e));
    @(posedge clk);
    #1;
    chk("win_valid", 72'(win_valid), 72'(exp_v));
    chk("frame_done", 72'(frame_done), 72'(exp_fd));
    if (frame_done) nfd++;
    if (win_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 72'(1), 72'(0));
      end else begin
        got = sb.pop_front();
        chk("win_out", win_out, got);
        last_win = got;
        nwin++;
      end
    end
  endtask

  task automatic pixels(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      step(1'b1, k / IMG_W, k % IMG_W);
    end
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    pix_in = '0;

    // Reset state, with en high to show lb_en follows en during reset.
    @(posedge clk);
    #1;
    en = 1'b1;
    #1;
    chk("rst_lb_en", 72'(lb_en), 72'(1));
    @(posedge clk);
    #1;
    chk("rst_win_valid", 72'(win_valid), 72'(0));
    chk("rst_frame_done", 72'(frame_done), 72'(0));
    chk("rst_win_out", win_out, 72'(0));
    en  = 1'b0;
    rst = 1'b1;

    // Test 1/2: single frame, explicit first window.
    nwin = 0; nfd = 0;
    pixels(0, 10);
    chk("t1_first_win", win_out, FIRST_WIN);
    pixels(11, 15);
    chk("t2_nwin", 72'(nwin), 72'(4));
    chk("t2_nfd", 72'(nfd), 72'(1));

    // Test 3: three stall cycles after pixel (2,2).
    nwin = 0; nfd = 0;
    pixels(0, 10);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 0);
      chk("t3_hold", win_out, last_win);
    end
    pixels(11, 15);
    chk("t3_nwin", 72'(nwin), 72'(4));
    chk("t3_nfd", 72'(nfd), 72'(1));

    // Test 4: two frames back to back.
    nwin = 0; nfd = 0;
    pixels(0, 15);
    pixels(0, 15);
    chk("t4_nwin", 72'(nwin), 72'(8));
    chk("t4_nfd", 72'(nfd), 72'(2));

    // Test 5: reset while pixel (2,1) is presented, then restart.
    nwin = 0; nfd = 0;
    pixels(0, 8);
    en     = 1'b1;
    pix_in = pix(2, 1);
    rst    = 1'b0;
    #1;
    chk("t5_lb_en_rst", 72'(lb_en), 72'(1));
    chk("t5_win_out_rst", win_out, 72'(0));
    chk("t5_valid_rst", 72'(win_valid), 72'(0));
    @(posedge clk);
    #1;
    chk("t5_valid_held", 72'(win_valid), 72'(0));
    rst = 1'b1;
    en  = 1'b0;
    pixels(0, 10);
    chk("t5_first_win", win_out, FIRST_WIN);
    pixels(11, 15);
    chk("t5_nwin", 72'(nwin), 72'(4));
    chk("t5_nfd", 72'(nfd), 72'(1));

    chk("sb_drained", 72'(sb.size()), 72'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
